// File: rtl/if_id_stage.sv
// IF/ID pipeline register: valid/ready handshake, synchronous flush, NOP bubble when empty.
// Optional two-entry skid buffer enabled by defining IF_ID_SKID_EN (registered in_ready).
module if_id_stage #(
  parameter int unsigned              INST_W   = 32,
  parameter int unsigned              PC_W     = 32,
  parameter logic [INST_W-1:0]        NOP_INST = INST_W'(32'h0000_0000)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [INST_W-1:0] in_inst,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [INST_W-1:0] out_inst,
  output logic [1:0]        occupancy
);

  // state | meaning
  // EMPTY | nothing held, M.inst = NOP_INST
  // ONE   | M holds a word, S empty
  // FULL  | M and S both hold words (skid build only)
  // Encoding is {M.valid, S.valid}; 2'b01 is illegal.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b10,
    FULL  = 2'b11
  } state_t;

  state_t            state, state_next;
  logic              m_valid, s_valid;
  logic              in_fire, out_fire;
  logic              m_load_in, m_clear;
  logic [PC_W-1:0]   m_pc;
  logic [INST_W-1:0] m_inst;

`ifdef IF_ID_SKID_EN
  logic              m_load_s, s_load;
  logic [PC_W-1:0]   s_pc;
  logic [INST_W-1:0] s_inst;
`endif

  assign m_valid  = (state != EMPTY);
`ifdef IF_ID_SKID_EN
  assign s_valid  = (state == FULL);
  // Depends only on registered state, so decode back-pressure never reaches fetch combinationally.
  assign in_ready = rst & ~s_valid;
`else
  assign s_valid  = 1'b0;
  assign in_ready = rst & (~m_valid | out_ready);
`endif

  assign in_fire   = in_valid & in_ready;
  assign out_fire  = m_valid & out_ready;
  assign out_valid = m_valid;
  assign out_pc    = m_pc;
  assign out_inst  = m_inst;
  assign occupancy = {1'b0, m_valid} + {1'b0, s_valid};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= EMPTY;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    m_load_in  = 1'b0;
`ifdef IF_ID_SKID_EN
    m_load_s   = 1'b0;
    s_load     = 1'b0;
`endif
    if (flush) begin
      // Flush wins over both handshakes; fire on either side is still honoured by the peers.
      state_next = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            state_next = ONE;
            m_load_in  = 1'b1;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            m_load_in  = 1'b1;
          end else if (out_fire) begin
            state_next = EMPTY;
`ifdef IF_ID_SKID_EN
          end else if (in_fire) begin
            state_next = FULL;
            s_load     = 1'b1;
`endif
          end
        end
`ifdef IF_ID_SKID_EN
        FULL: begin
          if (out_fire) begin
            state_next = ONE;
            m_load_s   = 1'b1;
          end
        end
`endif
        default: state_next = EMPTY;
      endcase
    end
  end

  assign m_clear = (state_next == EMPTY);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_pc   <= '0;
      m_inst <= NOP_INST;
    end else if (m_load_in) begin
      m_pc   <= in_pc;
      m_inst <= in_inst;
`ifdef IF_ID_SKID_EN
    end else if (m_load_s) begin
      m_pc   <= s_pc;
      m_inst <= s_inst;
`endif
    end else if (m_clear) begin
      m_inst <= NOP_INST;
    end
  end

`ifdef IF_ID_SKID_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_pc   <= '0;
      s_inst <= '0;
    end else if (s_load) begin
      s_pc   <= in_pc;
      s_inst <= in_inst;
    end
  end
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// Scoreboard bench for if_id_stage: directed scenarios plus random traffic with flush.
// Follows the build's IF_ID_SKID_EN setting for ready/capacity expectations.
module tb_if_id_stage;
  localparam int INST_W = 32;
  localparam int PC_W   = 32;
  localparam logic [INST_W-1:0] NOP = 32'h0000_0000;
`ifdef IF_ID_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } word_t;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [PC_W-1:0]   in_pc = '0;
  logic [INST_W-1:0] in_inst = '0;
  logic              flush = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [PC_W-1:0]   out_pc;
  logic [INST_W-1:0] out_inst;
  logic [1:0]        occupancy;

  word_t exp_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  if_id_stage #(.INST_W(INST_W), .PC_W(PC_W), .NOP_INST(NOP)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: run did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One cycle: drive at negedge, compare against the model, then advance the model over the edge.
  task automatic step(input logic v, input logic [PC_W-1:0] pc, input logic [INST_W-1:0] inst,
                      input logic ordy, input logic fl);
    logic exp_ready, in_f, out_f;
    @(negedge clk);
    in_valid  = v;
    in_pc     = pc;
    in_inst   = inst;
    out_ready = ordy;
    flush     = fl;
    #1;
    exp_ready = SKID ? (exp_q.size() < 2) : (exp_q.size() == 0 || ordy);
    check("in_ready", in_ready, exp_ready);
    check("out_valid", out_valid, exp_q.size() != 0);
    check("occupancy", occupancy, exp_q.size());
    if (exp_q.size() != 0) begin
      check("out_inst", out_inst, exp_q[0].inst);
      check("out_pc", out_pc, exp_q[0].pc);
    end else begin
      check("out_inst_nop", out_inst, NOP);
    end
    in_f  = v && exp_ready;
    out_f = (exp_q.size() != 0) && ordy;
    if (fl) begin
      exp_q.delete();
    end else begin
      if (out_f) void'(exp_q.pop_front());
      if (in_f) exp_q.push_back('{pc: pc, inst: inst});
    end
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, ordy, 1'b0);
  endtask

  initial begin
    logic [PC_W-1:0] pc_n;
    #3;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_pc", out_pc, 0);
    check("rst_out_inst", out_inst, NOP);
    check("rst_occupancy", occupancy, 0);
    check("rst_in_ready", in_ready, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    // streaming at full rate
    step(1'b1, 32'h0, 32'hA, 1'b1, 1'b0);
    step(1'b1, 32'h4, 32'hB, 1'b1, 1'b0);
    step(1'b1, 32'h8, 32'hC, 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b1);

    // stall then drain
    step(1'b1, 32'h10, 32'hA, 1'b0, 1'b0);
    step(1'b1, 32'h14, 32'hB, 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);

    // flush beats a simultaneous input fire
    step(1'b1, 32'h20, 32'h1, 1'b0, 1'b0);
    step(1'b1, 32'h24, 32'h2, 1'b0, 1'b0);
    step(1'b1, 32'h28, 32'hD, 1'b0, 1'b1);
    idle(1'b1);
    idle(1'b1);

    // flush beats a simultaneous output fire
    step(1'b1, 32'h30, 32'h3, 1'b0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
    idle(1'b1);

    // no-bubble replacement with decode always ready
    step(1'b1, 32'h40, 32'h5, 1'b1, 1'b0);
    step(1'b1, 32'h44, 32'h6, 1'b1, 1'b0);
    step(1'b1, 32'h48, 32'h7, 1'b0, 1'b0);
    step(1'b1, 32'h4C, 32'h8, 1'b0, 1'b0);
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);

    // async reset between edges while holding words
    step(1'b1, 32'h50, 32'h9, 1'b0, 1'b0);
    step(1'b1, 32'h54, 32'hE, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 1'b0);
    check("arst_in_ready", in_ready, 1'b0);
    check("arst_out_inst", out_inst, NOP);
    check("arst_occupancy", occupancy, 0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
    step(1'b1, 32'h60, 32'hF, 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b1);

    // random traffic
    pc_n = 32'h1000;
    for (int i = 0; i < 10000; i++) begin
      step($urandom_range(0, 3) != 0, pc_n, $urandom, $urandom_range(0, 9) < 7,
           $urandom_range(0, 31) == 0);
      pc_n = pc_n + 32'h4;
    end
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/if_id_stage.md
# if_id_stage

Parametrised IF/ID pipeline stage register with a valid/ready handshake, synchronous flush and an optional two-entry skid buffer. It sits between instruction fetch and decode and carries the fetched PC and instruction word. Back-pressure from decode stalls fetch cleanly, and squashed slots are presented to decode as a NOP bubble.

## Interface
- `INST_W`, 32: instruction width in bits.
- `PC_W`, 32: PC width in bits.
- `NOP_INST`, 32'h0000_0000: value driven on `out_inst` whenever `out_valid`=0. Must fit in `INST_W` bits.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  fetch presents a word.
- `in_ready`  out  1  stage accepts a word this cycle.
- `in_pc`  in  PC_W  PC of the offered word.
- `in_inst`  in  INST_W  offered instruction.
- `flush`  in  1  squash all held and incoming words (branch/exception redirect).
- `out_valid`  out  1  decode-side word valid.
- `out_ready`  in  1  decode consumes the word this cycle.
- `out_pc`  out  PC_W  PC of the held word.
- `out_inst`  out  INST_W  held instruction, or `NOP_INST` when not valid.
- `occupancy`  out  2  number of held words (0..2).

## Operation
- Input fire: `in_valid && in_ready`.
- Output fire: `out_valid && out_ready`.
- Storage:
  - Main register M (valid, pc, inst), which drives the out_* ports directly.
  - Skid register S (valid, pc, inst), present only with the skid macro.
- States, encoded by (M.valid, S.valid):
  - EMPTY (0,0)
  - ONE (1,0)
  - FULL (1,1)
  - (0,1) is illegal and unreachable.
- Transitions without flush:
  - EMPTY + input fire -> ONE.
  - ONE + input fire + output fire -> ONE; M takes the new word.
  - ONE + output fire only -> EMPTY.
  - ONE + input fire, no output fire -> FULL; the new word goes to S.
  - FULL + output fire -> ONE; S moves to M, S is cleared.
  - FULL with no output fire holds.
  - No input fire is possible in FULL.
- Whenever M becomes empty, M.inst loads `NOP_INST` and M.pc holds its previous value.
- `flush`=1 is evaluated at the clock edge:
  - Next state is EMPTY; M.inst loads `NOP_INST`.
  - Flush overrides a simultaneous input fire: that word is dropped, though fetch regards it as accepted.
  - Flush also overrides a simultaneous output fire: decode still consumed the word that cycle.
- Word order is strictly FIFO. No word is duplicated or lost except by flush.
- `occupancy` = M.valid + S.valid.

## Timing
- Latency: a word accepted at edge N is visible on out_* after edge N (one cycle) when M was empty or was being emptied. Otherwise it appears after the preceding word drains.
- With skid: `in_ready` = `rst` & !S.valid. This is a registered term with no combinational path from `out_ready`.
- Throughput: one word per cycle with `out_ready` held high.
- Reset, asynchronous while `rst`=0:
  - `out_valid`=0, `out_pc`=0, `out_inst`=`NOP_INST`, `occupancy`=0, `in_ready`=0.
  - On the first cycle after release, `in_ready`=1.
- Reset asserted mid-transfer discards M and S immediately without waiting for a clock edge.
- `in_pc` and `in_inst` are don't-care when `in_valid`=0.
- `out_pc` is undefined-but-stable when `out_valid`=0.

## Configuration
- `IF_ID_SKID_EN` defined: S is instantiated, the FULL state exists, and `in_ready` is registered as described above.
- `IF_ID_SKID_EN` undefined:
  - S is removed and `occupancy` ∈ {0,1}.
  - `in_ready` = `rst` & (!M.valid | `out_ready`), a combinational path from `out_ready`.
  - ONE with input fire and no output fire cannot occur.
  - All other rules are unchanged.

## Test plan
- Streaming: reset, then `out_ready`=1 with words PC 0x0,0x4,0x8 and inst 0xA,0xB,0xC on consecutive cycles -> `out_valid`=1 from cycle 1 with 0xA,0xB,0xC in order; `occupancy` stays 1.
- Stall (skid enabled): `out_ready`=0 while 0xA and 0xB are offered -> `occupancy`=2, `in_ready`=0, `out_inst`=0xA. Raising `out_ready` drains 0xA then 0xB, and `in_ready` returns to 1 one cycle after the first drain.
- Flush priority: in FULL, assert `flush` with `in_valid`=1 (inst 0xD) -> next cycle `out_valid`=0, `out_inst`=`NOP_INST`, `occupancy`=0; 0xD never appears.
- Async reset mid-stream: pull `rst` low between edges while in FULL -> `out_valid`=0, `in_ready`=0 and `out_inst`=`NOP_INST` before the next edge; after release, normal operation with no stale words.
- Skid disabled: `out_ready`=0 with M valid -> `in_ready`=0 in the same cycle; `out_ready`=1 with `in_valid`=1 -> M replaced each cycle with no bubble.
- Random traffic: random `in_valid`/`out_ready`/`flush` over 10k cycles -> outputs match a FIFO scoreboard that is cleared on flush; `occupancy` never reaches 3 and state (0,1) never occurs.
